fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Controller for the instruction-fetch stage of the 5-stage pipeline (15-bit PC, 20-bit instructions). Owns the PC register and the single instruction-memory port. Arbitrates that port between the program loader (BOOT) and instruction fetch (RUN). Drives the IF/ID register enable/clear from hazard (stall) and branch-redirect (flush) requests, stops fetch on a HALT opcode, and keeps a saturating fetch counter.

## Interface
Parameters:
- RESET_PC, 15'h0000: PC loaded on reset and on every BOOT→RUN transition
- HALT_OPC, 5'h1F: value of instr_f[19:15] that halts fetch

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- load_valid  in  1  loader drives a word this cycle
- load_addr  in  15  loader write address
- load_data  in  20  loader write data
- load_done  in  1  loader finished; leave BOOT
- boot_i  in  1  re-enter BOOT (honoured only in HALT)
- resume_i  in  1  leave HALT, continue fetching
- stall_i  in  1  hazard unit: hold PC and IF/ID
- flush_i  in  1  branch taken in EX (PCSrcE)
- pc_target_i  in  15  redirect target (PCTargetE)
- instr_f  in  20  instruction memory read data at mem_addr
- mem_addr  out  15  memory address (load_addr in BOOT, pc_f otherwise)
- mem_wdata  out  20  load_data
- mem_we  out  1  load_valid in BOOT, else 0
- pc_f  out  15  registered fetch PC
- ifid_en  out  1  IF/ID register load enable
- ifid_clr  out  1  IF/ID register synchronous clear (bubble)
- load_gnt  out  1  state == BOOT
- halted  out  1  state == HALT
- fetch_count  out  16  count of advanced fetches, saturating

## Operation
- States: BOOT, RUN, HALT. Reset → BOOT, pc_f = RESET_PC, fetch_count = 0.
- BOOT:
  - Memory port belongs to the loader. load_valid writes load_data to load_addr.
  - ifid_en = 0, ifid_clr = 1.
  - load_done → RUN, pc_f ← RESET_PC. A write in the same cycle as load_done is still performed.
- RUN: mem_we = 0. Priority per cycle is flush > halt > stall > advance.
  - flush_i: pc_f ← pc_target_i; ifid_en = 0, ifid_clr = 1. A flush during a stall is honoured.
  - instr_f[19:15] == HALT_OPC, no flush: the HALT word enters IF/ID (ifid_en = 1); pc_f holds; → HALT. Stall does not block halt detection.
  - stall_i: pc_f holds, ifid_en = 0, ifid_clr = 0.
  - Advance: pc_f ← pc_f + 1 (mod 2^15; 7FFF wraps to 0000), ifid_en = 1, fetch_count increments.
- HALT:
  - pc_f holds; ifid_en = 0, ifid_clr = 1 every cycle.
  - boot_i → BOOT. This takes priority over resume_i.
  - resume_i → RUN, pc_f ← pc_f + 1.
  - flush_i in HALT: pc_f ← pc_target_i, state stays HALT. This covers an older branch resolving after the HALT word was fetched.
- fetch_count saturates at 16'hFFFF and clears on every entry to BOOT.
- Combinational outputs (mem_*, ifid_*, load_gnt, halted) are pure functions of state and the current-cycle inputs.

## Timing
- Reset values: pc_f = RESET_PC, fetch_count = 0, load_gnt = 1, halted = 0, ifid_en = 0, ifid_clr = 1, mem_we = 0 unless load_valid.
- Reset asserted mid-operation returns the block to BOOT immediately and asynchronously. Any loader write in that cycle is dropped.
- Redirect latency: flush_i at edge k → pc_f = target after edge k. The target instruction is in IF/ID after edge k+1.
- Startup latency: load_done sampled at edge k → RUN with mem_addr = RESET_PC during cycle k+1. The first instruction is in IF/ID after edge k+1.
- stall_i and flush_i are level-sampled every edge. There is no handshake beyond that.

## Structure
- Package fetch_seq_pkg holds:
  - state enum {BOOT, RUN, HALT}
  - PC_W = 15, INSTR_W = 20, OPC_W = 5
  - default HALT_OPC
- One sub-module, sat_counter (width parameter, enable, synchronous clear, async active-low reset), implements fetch_count.

## Test plan
- Reset, then load words 0..3 (addr 0..3, data 20'h00001..00004) and assert load_done with the last write → all four written; pc_f = 0 in RUN; fetch_count increments from 0.
- Stall at pc_f = 5 for 3 cycles → pc_f stays 5, ifid_en = 0 for exactly 3 cycles; advance resumes to 6.
- stall_i and flush_i together, pc_target_i = 15'h0100 → pc_f = 0100, ifid_clr = 1, fetch_count unchanged.
- Program with pc_f at 7FFF advancing → pc_f = 0000.
- HALT word 20'hF8000 at addr 3:
  - Fetching it → halted = 1 next cycle, pc_f = 3, ifid_clr held at 1.
  - resume_i → pc_f = 4.
  - In HALT, boot_i and resume_i together → BOOT, fetch_count = 0.
- 70000 advances without stall → fetch_count = FFFF. Reset mid-run → BOOT, all outputs at reset values.

Source files
------------

// File: rtl/fetch_seq_pkg.sv
// Shared types and widths for the instruction-fetch controller.
package fetch_seq_pkg;

   localparam int unsigned PC_W    = 15;
   localparam int unsigned INSTR_W = 20;
   localparam int unsigned OPC_W   = 5;
   localparam int unsigned CNT_W   = 16;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_e;

   localparam logic [OPC_W-1:0] HALT_OPC_DEF = 5'h1F;

   // Opcode field sits in the top bits of the instruction word.
   function automatic logic [OPC_W-1:0] opcode(input logic [INSTR_W-1:0] instr);
      return instr[INSTR_W-1 -: OPC_W];
   endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Loader, pipeline-control and instruction-memory signals of the fetch controller.
interface fetch_sequencer_if;
   import fetch_seq_pkg::*;

   logic               load_valid;
   logic [PC_W-1:0]    load_addr;
   logic [INSTR_W-1:0] load_data;
   logic               load_done;
   logic               boot_i;
   logic               resume_i;
   logic               stall_i;
   logic               flush_i;
   logic [PC_W-1:0]    pc_target_i;
   logic [INSTR_W-1:0] instr_f;
   logic [PC_W-1:0]    mem_addr;
   logic [INSTR_W-1:0] mem_wdata;
   logic               mem_we;
   logic [PC_W-1:0]    pc_f;
   logic               ifid_en;
   logic               ifid_clr;
   logic               load_gnt;
   logic               halted;
   logic [CNT_W-1:0]   fetch_count;

   // Environment side: loader, hazard unit, memory.
   modport master (
      output load_valid, load_addr, load_data, load_done, boot_i, resume_i,
             stall_i, flush_i, pc_target_i, instr_f,
      input  mem_addr, mem_wdata, mem_we, pc_f, ifid_en, ifid_clr, load_gnt,
             halted, fetch_count
   );

   // Controller side.
   modport slave (
      input  load_valid, load_addr, load_data, load_done, boot_i, resume_i,
             stall_i, flush_i, pc_target_i, instr_f,
      output mem_addr, mem_wdata, mem_we, pc_f, ifid_en, ifid_clr, load_gnt,
             halted, fetch_count
   );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module sat_counter #(
   parameter int unsigned Width = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [Width-1:0] count_o
);

   logic [Width-1:0] count_q, count_d;

   // Next count: clear, else step unless already at all-ones.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && !(&count_q)) begin
         count_d = count_q + Width'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC and the single imem port, shares the
// port with the program loader, and drives IF/ID enable/clear from stall/flush/halt.
module fetch_sequencer
   import fetch_seq_pkg::*;
#(
   parameter logic [PC_W-1:0]  RESET_PC = 15'h0000,
   parameter logic [OPC_W-1:0] HALT_OPC = HALT_OPC_DEF
) (
   input  logic              clk,
   input  logic              reset,
   fetch_sequencer_if.slave  bus
);

   localparam logic [1:0] ST_BOOT = BOOT;
   localparam logic [1:0] ST_RUN  = RUN;
   localparam logic [1:0] ST_HALT = HALT;

   logic [1:0]      state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            cnt_en, cnt_clr;
   logic            mem_we_raw;
   logic            halt_word;

   assign halt_word = (opcode(bus.instr_f) == HALT_OPC);

   // Next-state, PC and port/pipeline control; priority flush > halt > stall > advance.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      cnt_en       = 1'b0;
      cnt_clr      = 1'b0;
      mem_we_raw   = 1'b0;
      bus.mem_addr = pc_q;
      bus.ifid_en  = 1'b0;
      bus.ifid_clr = 1'b0;
      unique case (state_q)
         ST_BOOT: begin
            bus.mem_addr = bus.load_addr;
            mem_we_raw   = bus.load_valid;
            bus.ifid_clr = 1'b1;
            if (bus.load_done) begin
               state_d = ST_RUN;
               pc_d    = RESET_PC;
            end
         end
         ST_RUN: begin
            if (bus.flush_i) begin
               pc_d         = bus.pc_target_i;
               bus.ifid_clr = 1'b1;
            end else if (halt_word) begin
               // HALT word still latches into IF/ID; PC parks on it.
               bus.ifid_en = 1'b1;
               state_d     = ST_HALT;
            end else if (!bus.stall_i) begin
               pc_d        = pc_q + PC_W'(1);
               bus.ifid_en = 1'b1;
               cnt_en      = 1'b1;
            end
         end
         ST_HALT: begin
            bus.ifid_clr = 1'b1;
            if (bus.boot_i) begin
               state_d = ST_BOOT;
               cnt_clr = 1'b1;
            end else if (bus.resume_i) begin
               state_d = ST_RUN;
               pc_d    = pc_q + PC_W'(1);
            end else if (bus.flush_i) begin
               // An older branch resolving behind the HALT word still redirects.
               pc_d = bus.pc_target_i;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // A loader write coinciding with reset assertion is dropped.
   assign bus.mem_we    = mem_we_raw & reset;
   assign bus.mem_wdata = bus.load_data;
   assign bus.pc_f      = pc_q;
   assign bus.load_gnt  = (state_q == ST_BOOT);
   assign bus.halted    = (state_q == ST_HALT);

   // State and PC registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   sat_counter #(
      .Width (CNT_W)
   ) u_fetch_cnt (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (cnt_clr),
      .en_i    (cnt_en),
      .count_o (bus.fetch_count)
   );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer with a behavioural memory and scoreboard.
module tb_fetch_sequencer;
   import fetch_seq_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;

   fetch_sequencer_if bus ();

   fetch_sequencer #(
      .RESET_PC (15'h0000),
      .HALT_OPC (5'h1F)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [19:0] mem [0:32767];
   assign bus.instr_f = mem[bus.mem_addr];
   always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

   typedef struct packed {
      logic [1:0]  st;
      logic [14:0] pc;
      logic [15:0] cnt;
   } exp_t;

   exp_t        sb_q[$];
   int          n_tests = 0;
   int          n_fail = 0;
   logic [1:0]  m_st;
   logic [14:0] m_pc;
   logic [15:0] m_cnt;
   int          ifid_low;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // One clock: drive inputs, check combinational outputs, push expected state,
   // then pop and compare the registered outputs after the edge.
   task automatic step(input logic lv, input logic [14:0] la, input logic [19:0] ld,
                       input logic done, input logic boot, input logic res,
                       input logic stall, input logic flush, input logic [14:0] tgt);
      exp_t e;
      logic hw;
      @(negedge clk);
      bus.load_valid  = lv;
      bus.load_addr   = la;
      bus.load_data   = ld;
      bus.load_done   = done;
      bus.boot_i      = boot;
      bus.resume_i    = res;
      bus.stall_i     = stall;
      bus.flush_i     = flush;
      bus.pc_target_i = tgt;
      #1;
      hw = (mem[m_pc][19:15] == 5'h1F);
      check_eq("load_gnt", bus.load_gnt, m_st == 2'd0);
      check_eq("halted", bus.halted, m_st == 2'd2);
      check_eq("ifid_en", bus.ifid_en, (m_st == 2'd1) && !flush && (hw || !stall));
      check_eq("ifid_clr", bus.ifid_clr, (m_st != 2'd1) || flush);
      check_eq("mem_we", bus.mem_we, (m_st == 2'd0) && lv);
      check_eq("mem_addr", bus.mem_addr, (m_st == 2'd0) ? la : m_pc);
      if (!bus.ifid_en) ifid_low++;
      e = '{st: m_st, pc: m_pc, cnt: m_cnt};
      case (m_st)
         2'd0: if (done) begin e.st = 2'd1; e.pc = 15'h0000; end
         2'd1: begin
            if (flush) e.pc = tgt;
            else if (hw) e.st = 2'd2;
            else if (!stall) begin
               e.pc = m_pc + 15'd1;
               if (m_cnt != 16'hFFFF) e.cnt = m_cnt + 16'd1;
            end
         end
         default: begin
            if (boot) begin e.st = 2'd0; e.cnt = 16'h0; end
            else if (res) begin e.st = 2'd1; e.pc = m_pc + 15'd1; end
            else if (flush) e.pc = tgt;
         end
      endcase
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check_eq("pc_f", bus.pc_f, e.pc);
      check_eq("fetch_count", bus.fetch_count, e.cnt);
      check_eq("state_boot", bus.load_gnt, e.st == 2'd0);
      check_eq("state_halt", bus.halted, e.st == 2'd2);
      m_st  = e.st;
      m_pc  = e.pc;
      m_cnt = e.cnt;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) mem[i] = 20'h0;
      bus.load_valid = 0; bus.load_addr = 0; bus.load_data = 0; bus.load_done = 0;
      bus.boot_i = 0; bus.resume_i = 0; bus.stall_i = 0; bus.flush_i = 0;
      bus.pc_target_i = 0;
      m_st = 2'd0; m_pc = 15'h0; m_cnt = 16'h0;
      ifid_low = 0;

      // Reset values.
      #12;
      check_eq("rst_pc", bus.pc_f, 15'h0000);
      check_eq("rst_cnt", bus.fetch_count, 16'h0);
      check_eq("rst_gnt", bus.load_gnt, 1'b1);
      check_eq("rst_halted", bus.halted, 1'b0);
      check_eq("rst_ifid_en", bus.ifid_en, 1'b0);
      check_eq("rst_ifid_clr", bus.ifid_clr, 1'b1);
      check_eq("rst_mem_we", bus.mem_we, 1'b0);
      @(negedge clk);
      reset = 1'b1;

      // Session 1: a HALT word at 0x40, then words 0..3 with load_done on the last.
      step(1, 15'h0040, 20'hF8000, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(1, 15'(i), 20'(i + 1), i == 3, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) check_eq("load_word", mem[i], 20'(i + 1));
      check_eq("run_pc0", bus.pc_f, 15'h0000);
      check_eq("run_gnt", bus.load_gnt, 1'b0);

      idle(5);
      check_eq("pc_at5", bus.pc_f, 15'h0005);
      check_eq("cnt_at5", bus.fetch_count, 16'd5);

      // Three-cycle stall, then advance.
      ifid_low = 0;
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 0);
      check_eq("stall_pc", bus.pc_f, 15'h0005);
      idle(1);
      check_eq("stall_low_cycles", ifid_low, 3);
      check_eq("after_stall_pc", bus.pc_f, 15'h0006);

      // Flush during stall.
      step(0, 0, 0, 0, 0, 0, 1, 1, 15'h0100);
      check_eq("flush_pc", bus.pc_f, 15'h0100);
      check_eq("flush_cnt", bus.fetch_count, 16'd6);

      // PC wrap.
      step(0, 0, 0, 0, 0, 0, 0, 1, 15'h7FFF);
      check_eq("pc_7fff", bus.pc_f, 15'h7FFF);
      idle(1);
      check_eq("pc_wrap", bus.pc_f, 15'h0000);

      // Reach the HALT word at 0x40 and reboot.
      step(0, 0, 0, 0, 0, 0, 0, 1, 15'h0040);
      idle(1);
      check_eq("halt40", bus.halted, 1'b1);
      step(0, 0, 0, 0, 1, 0, 0, 0, 0);
      check_eq("reboot_gnt", bus.load_gnt, 1'b1);

      // Session 2: HALT word at address 3.
      step(1, 15'h0003, 20'hF8000, 1, 0, 0, 0, 0, 0);
      idle(3);
      check_eq("pre_halt_pc", bus.pc_f, 15'h0003);
      idle(1);
      check_eq("halt_flag", bus.halted, 1'b1);
      check_eq("halt_pc", bus.pc_f, 15'h0003);
      idle(2);
      check_eq("halt_hold_pc", bus.pc_f, 15'h0003);
      step(0, 0, 0, 0, 0, 1, 0, 0, 0);
      check_eq("resume_pc", bus.pc_f, 15'h0004);
      check_eq("resume_run", bus.halted, 1'b0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 15'h0003);
      idle(1);
      check_eq("halt_again", bus.halted, 1'b1);
      step(0, 0, 0, 0, 0, 0, 0, 1, 15'h0010);
      check_eq("halt_flush_pc", bus.pc_f, 15'h0010);
      check_eq("halt_flush_stay", bus.halted, 1'b1);
      step(0, 0, 0, 0, 1, 1, 0, 0, 0);
      check_eq("boot_wins", bus.load_gnt, 1'b1);
      check_eq("boot_cnt_clr", bus.fetch_count, 16'h0);

      // Session 3: remove the HALT words, then saturate the counter.
      step(1, 15'h0040, 20'h0, 0, 0, 0, 0, 0, 0);
      step(1, 15'h0003, 20'h0, 1, 0, 0, 0, 0, 0);
      idle(70000);
      check_eq("cnt_sat", bus.fetch_count, 16'hFFFF);

      // Asynchronous reset mid-run with a loader write pending.
      @(negedge clk);
      bus.load_valid = 1;
      bus.load_addr  = 15'h0005;
      bus.load_data  = 20'hABCDE;
      #2;
      reset = 1'b0;
      #1;
      check_eq("mid_rst_gnt", bus.load_gnt, 1'b1);
      check_eq("mid_rst_halted", bus.halted, 1'b0);
      check_eq("mid_rst_pc", bus.pc_f, 15'h0000);
      check_eq("mid_rst_cnt", bus.fetch_count, 16'h0);
      check_eq("mid_rst_ifid_en", bus.ifid_en, 1'b0);
      check_eq("mid_rst_ifid_clr", bus.ifid_clr, 1'b1);
      check_eq("mid_rst_mem_we", bus.mem_we, 1'b0);
      @(posedge clk);
      #1;
      check_eq("mid_rst_drop", mem[5], 20'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
